neo_p2_fetch_arb: RTL

//  Arbitrates and sequences the single SDRAM port that backs the banked P2 program ROM.

---
 rtl/neo_p2_fetch_arb.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/neo_p2_fetch_arb.sv
// neo_p2_fetch_arb
// Arbitrates the single SDRAM port that backs the banked P2 program ROM between the 68K read
// path (SMA-translated address, level request while the port window is read) and the ROM
// loader write path. Returns read words to the 68K data mux.
//
// Ports
//   clk_48m_i     system clock
//   reset_i       synchronous, active-high reset (shared with the SDRAM controller)
//   p2_rd_i       level: 68K reading the P2 window
//   p2_addr_i     translated byte address; bit 0 ignored (16-bit words)
//   p2_dout_o     read data; holds the last delivered word
//   p2_valid_o    one-cycle pulse: p2_dout_o is valid for the current p2_rd_i/p2_addr_i
//   ldr_wr_i      level: loader write request, held until ldr_ack_o
//   ldr_addr_i    loader byte address
//   ldr_data_i    loader write data
//   ldr_ack_o     one-cycle pulse: loader write completed
//   sdr_req_o     SDRAM request, held until sdr_ack_i
//   sdr_we_o      1 = write, 0 = read
//   sdr_addr_o    SDRAM byte address, bit 0 forced to 0
//   sdr_wdata_o   SDRAM write data
//   sdr_ack_i     one-cycle pulse; sdr_rdata_i valid in the same cycle for reads
//   sdr_rdata_i   SDRAM read data
//
// Build option
//   NEO_P2_HITREG_EN  adds a one-entry hit register {valid, word address, data} that serves
//                     repeat CPU reads from IDLE without an SDRAM access.
//
// STARVE_MAX must be at least 1.

module neo_p2_fetch_arb #(
    parameter int unsigned AW         = 24,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic          clk_48m_i,
    input  logic          reset_i,
    input  logic          p2_rd_i,
    input  logic [AW-1:0] p2_addr_i,
    output logic [15:0]   p2_dout_o,
    output logic          p2_valid_o,
    input  logic          ldr_wr_i,
    input  logic [AW-1:0] ldr_addr_i,
    input  logic [15:0]   ldr_data_i,
    output logic          ldr_ack_o,
    output logic          sdr_req_o,
    output logic          sdr_we_o,
    output logic [AW-1:0] sdr_addr_o,
    output logic [15:0]   sdr_wdata_o,
    input  logic          sdr_ack_i,
    input  logic [15:0]   sdr_rdata_i
);

    localparam int unsigned   CW        = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] StarveMax = CW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StCpuRd, StLdrWr, StResp} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          served_q, served_d;
    logic [AW-2:0] served_addr_q, served_addr_d;
    logic [15:0]   p2_dout_q, p2_dout_d;
    logic          p2_valid_q, p2_valid_d;
    logic          ldr_ack_q, ldr_ack_d;
    logic          sdr_req_q, sdr_req_d;
    logic          sdr_we_q, sdr_we_d;
    logic [AW-1:0] sdr_addr_q, sdr_addr_d;
    logic [15:0]   sdr_wdata_q, sdr_wdata_d;

    logic [AW-2:0] p2_word;
    logic [AW-2:0] sdr_word;
    logic          cpu_demand;
    logic          cpu_hit;
    logic          cpu_miss;
    logic          ldr_grant;
    logic          rd_live;
    logic          unused_addr_lsb;

    assign p2_word  = p2_addr_i[AW-1:1];
    assign sdr_word = sdr_addr_q[AW-1:1];
    // Byte lane bits carry no information for word accesses.
    assign unused_addr_lsb = p2_addr_i[0] ^ ldr_addr_i[0];

    // A served read only suppresses demand while the same word is still being read, so an
    // address change re-arms demand in the same cycle.
    assign cpu_demand = p2_rd_i & ~(served_q & (p2_word == served_addr_q));
    // Read data is only delivered if the CPU still wants the word that was fetched.
    assign rd_live    = p2_rd_i & (p2_word == sdr_word);

`ifdef NEO_P2_HITREG_EN
    logic          hit_vld_q, hit_vld_d;
    logic [AW-2:0] hit_addr_q, hit_addr_d;
    logic [15:0]   hit_data_q, hit_data_d;

    assign cpu_hit = hit_vld_q & (hit_addr_q == p2_word);
`else
    assign cpu_hit = 1'b0;
`endif

    // Hits never touch SDRAM, so only misses compete with the loader.
    assign cpu_miss  = cpu_demand & ~cpu_hit;
    assign ldr_grant = (state_q == StIdle) & ldr_wr_i &
                       (~cpu_miss | (starve_cnt_q >= StarveMax));

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        served_d      = served_q & p2_rd_i & (p2_word == served_addr_q);
        served_addr_d = served_addr_q;
        p2_dout_d     = p2_dout_q;
        p2_valid_d    = 1'b0;
        ldr_ack_d     = 1'b0;
        sdr_req_d     = sdr_req_q;
        sdr_we_d      = sdr_we_q;
        sdr_addr_d    = sdr_addr_q;
        sdr_wdata_d   = sdr_wdata_q;
`ifdef NEO_P2_HITREG_EN
        hit_vld_d     = hit_vld_q;
        hit_addr_d    = hit_addr_q;
        hit_data_d    = hit_data_q;
`endif

        unique case (state_q)
            StIdle: begin
`ifdef NEO_P2_HITREG_EN
                if (cpu_demand && cpu_hit) begin
                    p2_dout_d     = hit_data_q;
                    p2_valid_d    = 1'b1;
                    served_d      = 1'b1;
                    served_addr_d = p2_word;
                end
`endif
                if (ldr_grant) begin
                    state_d      = StLdrWr;
                    starve_cnt_d = '0;
                    sdr_req_d    = 1'b1;
                    sdr_we_d     = 1'b1;
                    sdr_addr_d   = {ldr_addr_i[AW-1:1], 1'b0};
                    sdr_wdata_d  = ldr_data_i;
                end else begin
                    if (ldr_wr_i && (starve_cnt_q < StarveMax)) begin
                        starve_cnt_d = starve_cnt_q + CW'(1);
                    end
                    if (cpu_miss) begin
                        state_d    = StCpuRd;
                        sdr_req_d  = 1'b1;
                        sdr_we_d   = 1'b0;
                        sdr_addr_d = {p2_word, 1'b0};
                    end
                end
            end
            StCpuRd: begin
                if (sdr_ack_i) begin
                    state_d   = StResp;
                    sdr_req_d = 1'b0;
                    if (rd_live) begin
                        p2_dout_d     = sdr_rdata_i;
                        p2_valid_d    = 1'b1;
                        served_d      = 1'b1;
                        served_addr_d = sdr_word;
                    end
`ifdef NEO_P2_HITREG_EN
                    // Filled even when the data is discarded; it is still the correct word.
                    hit_vld_d  = 1'b1;
                    hit_addr_d = sdr_word;
                    hit_data_d = sdr_rdata_i;
`endif
                end
            end
            StLdrWr: begin
                if (sdr_ack_i) begin
                    state_d   = StResp;
                    sdr_req_d = 1'b0;
                    ldr_ack_d = 1'b1;
`ifdef NEO_P2_HITREG_EN
                    if (hit_vld_q && (hit_addr_q == sdr_word)) begin
                        hit_data_d = sdr_wdata_q;
                    end
`endif
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_48m_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            starve_cnt_q  <= '0;
            served_q      <= 1'b0;
            served_addr_q <= '0;
            p2_dout_q     <= '0;
            p2_valid_q    <= 1'b0;
            ldr_ack_q     <= 1'b0;
            sdr_req_q     <= 1'b0;
            sdr_we_q      <= 1'b0;
            sdr_addr_q    <= '0;
            sdr_wdata_q   <= '0;
`ifdef NEO_P2_HITREG_EN
            hit_vld_q     <= 1'b0;
            hit_addr_q    <= '0;
            hit_data_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            served_q      <= served_d;
            served_addr_q <= served_addr_d;
            p2_dout_q     <= p2_dout_d;
            p2_valid_q    <= p2_valid_d;
            ldr_ack_q     <= ldr_ack_d;
            sdr_req_q     <= sdr_req_d;
            sdr_we_q      <= sdr_we_d;
            sdr_addr_q    <= sdr_addr_d;
            sdr_wdata_q   <= sdr_wdata_d;
`ifdef NEO_P2_HITREG_EN
            hit_vld_q     <= hit_vld_d;
            hit_addr_q    <= hit_addr_d;
            hit_data_q    <= hit_data_d;
`endif
        end
    end

    assign p2_dout_o   = p2_dout_q;
    assign p2_valid_o  = p2_valid_q;
    assign ldr_ack_o   = ldr_ack_q;
    assign sdr_req_o   = sdr_req_q;
    assign sdr_we_o    = sdr_we_q;
    assign sdr_addr_o  = sdr_addr_q;
    assign sdr_wdata_o = sdr_wdata_q;

endmodule
